// File: rtl/cpu_types_pkg.sv
// Shared types and address-split helpers for the set-associative icache.
package cpu_types_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Width of a select field for n items; never narrower than one bit.
  function automatic int field_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag width after removing byte offset, word offset and index.
  function automatic int tag_bits(input int sets, input int blkwords);
    return 30 - $clog2(sets) - $clog2(blkwords);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag array and block data array.
// Read is asynchronous so the hit path stays single-cycle.
module icache_way
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2,
  parameter int TAGW     = 26
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic [$clog2(SETS)-1:0]          rd_idx,
  input  logic [field_bits(BLKWORDS)-1:0]  rd_word,
  output logic                             rd_valid,
  output logic [TAGW-1:0]                  rd_tag,
  output logic [31:0]                      rd_data,
  input  logic                             wr_en,
  input  logic [$clog2(SETS)-1:0]          wr_idx,
  input  logic [field_bits(BLKWORDS)-1:0]  wr_word,
  input  logic [31:0]                      wr_data,
  input  logic                             set_valid,
  input  logic [TAGW-1:0]                  set_tag,
  input  logic                             clr_valid,
  input  logic                             clr_all
);

  localparam int AW = $clog2(SETS * BLKWORDS);

  logic [SETS-1:0] valid_reg;
  logic [TAGW-1:0] tag_mem [SETS];
  logic [31:0]     data_mem [SETS * BLKWORDS];
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;

  generate
    if (BLKWORDS > 1) begin : g_multi
      assign rd_addr = {rd_idx, rd_word};
      assign wr_addr = {wr_idx, wr_word};
    end else begin : g_single
      logic word_sel_unused;
      assign word_sel_unused = rd_word[0] ^ wr_word[0];
      assign rd_addr = rd_idx;
      assign wr_addr = wr_idx;
    end
  endgenerate

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_addr];

  // Valid bits: cleared by reset or flush, cleared on fill entry, set on fill completion.
  always_ff @(posedge clk) begin
    if (srst || clr_all) begin
      valid_reg <= '0;
    end else if (set_valid) begin
      valid_reg[wr_idx] <= 1'b1;
    end else if (clr_valid) begin
      valid_reg[wr_idx] <= 1'b0;
    end
  end

  // Tag and data arrays are not reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (set_valid) tag_mem[wr_idx] <= set_tag;
    if (wr_en)     data_mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word block fills,
// per-set round-robin replacement and an invalidate-all flush.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int WOFF = $clog2(BLKWORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = tag_bits(SETS, BLKWORDS);
  localparam int WSEL = field_bits(BLKWORDS);
  localparam int VW   = field_bits(WAYS);
  localparam logic [WSEL-1:0] LAST_BEAT = WSEL'(BLKWORDS - 1);

  icache_state_t   state_reg;
  logic [TAGW-1:0] miss_tag_reg;
  logic [IDXW-1:0] miss_idx_reg;
  logic [WSEL-1:0] beat_reg;
  logic [VW-1:0]   victim_reg;

  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx;
  logic [WSEL-1:0] req_word;
  logic            byte_off_unused;

  logic [WAYS-1:0] way_valid;
  logic [WAYS-1:0] way_match;
  logic [WAYS-1:0] way_wr;
  logic [WAYS-1:0] way_set;
  logic [WAYS-1:0] way_clr;
  logic [TAGW-1:0] way_tag  [WAYS];
  logic [31:0]     way_data [WAYS];

  logic            any_match;
  logic            lookup_hit;
  logic            miss_start;
  logic            beat_ok;
  logic            last_beat;
  logic [31:0]     hit_data;
  logic [VW-1:0]   vptr_cur;
  logic [VW-1:0]   victim_pick;
  logic [IDXW-1:0] wr_idx;
  logic [31:0]     fill_addr;

  // Address split of the live fetch address.
  assign byte_off_unused = ^imemaddr[1:0];
  assign req_tag = imemaddr[31 -: TAGW];
  assign req_idx = imemaddr[2 + WOFF +: IDXW];

  generate
    if (BLKWORDS > 1) begin : g_word
      assign req_word  = imemaddr[2 +: WOFF];
      assign fill_addr = {miss_tag_reg, miss_idx_reg, beat_reg, 2'b00};
    end else begin : g_noword
      assign req_word  = '0;
      assign fill_addr = {miss_tag_reg, miss_idx_reg, 2'b00};
    end
  endgenerate

  assign any_match  = |way_match;
  assign lookup_hit = imemREN && (state_reg == IDLE) && any_match;
  assign miss_start = imemREN && (state_reg == IDLE) && !any_match && !flush;
  assign beat_ok    = (state_reg == FILL) && !iwait && !flush;
  assign last_beat  = (beat_reg == LAST_BEAT);
  assign wr_idx     = (state_reg == FILL) ? miss_idx_reg : req_idx;

  assign ihit     = lookup_hit && !flush;
  assign imemload = ihit ? hit_data : 32'h0;
  assign iREN     = (state_reg == FILL);
  assign iaddr    = (state_reg == FILL) ? fill_addr : 32'h0;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      icache_way #(
        .SETS     (SETS),
        .BLKWORDS (BLKWORDS),
        .TAGW     (TAGW)
      ) u_way (
        .clk       (CLK),
        .srst      (RST),
        .rd_idx    (req_idx),
        .rd_word   (req_word),
        .rd_valid  (way_valid[gi]),
        .rd_tag    (way_tag[gi]),
        .rd_data   (way_data[gi]),
        .wr_en     (way_wr[gi]),
        .wr_idx    (wr_idx),
        .wr_word   (beat_reg),
        .wr_data   (iload),
        .set_valid (way_set[gi]),
        .set_tag   (miss_tag_reg),
        .clr_valid (way_clr[gi]),
        .clr_all   (flush)
      );

      assign way_match[gi] = way_valid[gi] && (way_tag[gi] == req_tag);
      assign way_wr[gi]    = beat_ok && (victim_reg == VW'(gi));
      assign way_set[gi]   = way_wr[gi] && last_beat;
      assign way_clr[gi]   = miss_start && (victim_pick == VW'(gi));
    end
  endgenerate

  // Per-set round-robin pointer, advanced when a fill completes.
  generate
    if (WAYS > 1) begin : g_vptr
      logic [VW-1:0] vptr_reg [SETS];
      assign vptr_cur = vptr_reg[req_idx];

      // Pointer update; reset returns every set to way 0.
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int s = 0; s < SETS; s++) vptr_reg[s] <= '0;
        end else if (beat_ok && last_beat) begin
          vptr_reg[miss_idx_reg] <= vptr_reg[miss_idx_reg] + 1'b1;
        end
      end
    end else begin : g_novptr
      assign vptr_cur = '0;
    end
  endgenerate

  // Hit mux: data of the matching way.
  always_comb begin
    hit_data = 32'h0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_match[w]) hit_data = way_data[w];
    end
  end

  // Victim choice: lowest invalid way first, else the round-robin pointer.
  always_comb begin
    logic found;
    found       = 1'b0;
    victim_pick = vptr_cur;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !way_valid[w]) begin
        victim_pick = VW'(w);
        found       = 1'b1;
      end
    end
  end

  // Miss/fill FSM with latched miss address and beat counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      miss_tag_reg <= '0;
      miss_idx_reg <= '0;
      beat_reg     <= '0;
      victim_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (miss_start) begin
            state_reg    <= FILL;
            miss_tag_reg <= req_tag;
            miss_idx_reg <= req_idx;
            beat_reg     <= '0;
            victim_reg   <= victim_pick;
          end
        end
        FILL: begin
          if (flush) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
          end else if (!iwait) begin
            if (last_beat) begin
              state_reg <= IDLE;
              beat_reg  <= '0;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc (SETS=8, WAYS=2, BLKWORDS=2).
module tb_icache_assoc;

  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int BLKWORDS = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        flush = 1'b0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b0;
  logic [31:0] iload = 32'h0;

  int total = 0;
  int bad = 0;

  icache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKWORDS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  // Backing memory contents.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA_0001;
    if (a == 32'h44) return 32'hAAAA_0002;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of hand-driven stimulus; outputs are settled on return.
  task automatic step(input bit ren, input logic [31:0] a, input bit fl, input bit rs);
    @(negedge CLK);
    imemREN  = ren;
    imemaddr = a;
    flush    = fl;
    RST      = rs;
    iwait    = 1'b0;
    iload    = mem_data(iaddr);
    #1;
  endtask

  // Full fetch with a memory responder. waits < 0 picks 0..2 wait cycles per beat.
  task automatic do_fetch(input logic [31:0] addr, input int waits,
                          output int lat, output logic [31:0] data, output int waits_used);
    int beats, wait_cnt, cur_wait;
    logic [31:0] base;
    base = addr & ~32'(BLKWORDS * 4 - 1);
    lat = -1; data = 32'h0; beats = 0; wait_cnt = 0; waits_used = 0;
    cur_wait = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = addr; flush = 1'b0; RST = 1'b0;
      if (iREN) begin
        chk("iaddr", iaddr, base + 32'(beats * 4));
        if (wait_cnt < cur_wait) begin
          iwait = 1'b1; iload = 32'hDEAD_BEEF;
          wait_cnt++; waits_used++;
        end else begin
          iwait = 1'b0; iload = mem_data(base + 32'(beats * 4));
          beats++; wait_cnt = 0;
          cur_wait = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
        end
      end else begin
        iwait = 1'b0; iload = 32'hDEAD_BEEF;
      end
      #1;
      if (ihit) begin
        lat = c; data = imemload;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL fetch_timeout: addr %h got no ihit required ihit within 200 cycles", addr);
    end
    $display("fetch addr=%h lat=%0d data=%h waits=%0d", addr, lat, data, waits_used);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          waits;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  // Reference model: cache contents as sets of (valid, tag) plus round-robin pointer.
  bit mv [SETS][WAYS];
  int mt [SETS][WAYS];
  int mp [SETS];

  function automatic bit model_hit(input logic [31:0] a);
    int s, t;
    s = int'((a / (BLKWORDS * 4)) % SETS);
    t = int'(a / (BLKWORDS * 4 * SETS));
    for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input logic [31:0] a);
    int s, t, v;
    s = int'((a / (BLKWORDS * 4)) % SETS);
    t = int'(a / (BLKWORDS * 4 * SETS));
    v = -1;
    for (int w = 0; w < WAYS; w++) if (v < 0 && !mv[s][w]) v = w;
    if (v < 0) v = mp[s];
    mv[s][v] = 1'b1; mt[s][v] = t;
    mp[s] = (mp[s] + 1) % WAYS;
  endtask

  task automatic model_clear(input bit with_ptrs);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
      if (with_ptrs) mp[s] = 0;
    end
  endtask

  initial begin
    vec_t vecs [8];
    int lat, wu;
    logic [31:0] data;

    vecs[0] = '{32'h040, 0, 3, 32'hAAAA_0001};
    vecs[1] = '{32'h044, 0, 0, 32'hAAAA_0002};
    vecs[2] = '{32'h240, 0, 3, 32'hC0DE_0240};
    vecs[3] = '{32'h440, 0, 3, 32'hC0DE_0440};
    vecs[4] = '{32'h244, 0, 0, 32'hC0DE_0244};
    vecs[5] = '{32'h040, 0, 3, 32'hAAAA_0001};
    vecs[6] = '{32'h080, 3, 9, 32'hC0DE_0080};
    vecs[7] = '{32'h084, 0, 0, 32'hC0DE_0084};

    // Reset values
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 0);
    chk("rst_ihit", 32'(ihit), 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iREN", 32'(iREN), 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);

    // Table: cold miss, hit, conflict replacement, wait states
    foreach (vecs[i]) begin
      do_fetch(vecs[i].addr, vecs[i].waits, lat, data, wu);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end

    // Address change mid-fill
    step(0, 32'h0, 1, 0);
    step(1, 32'h040, 0, 0); chk("mid_miss_ihit", 32'(ihit), 32'h0);
    step(1, 32'h100, 0, 0); chk("mid_b0_iREN", 32'(iREN), 32'h1);
    chk("mid_b0_iaddr", iaddr, 32'h40);
    step(1, 32'h100, 0, 0); chk("mid_b1_iaddr", iaddr, 32'h44);
    step(1, 32'h100, 0, 0); chk("mid_new_miss_ihit", 32'(ihit), 32'h0);
    chk("mid_idle_iREN", 32'(iREN), 32'h0);
    step(1, 32'h100, 0, 0); chk("mid_new_b0_iaddr", iaddr, 32'h100);
    step(1, 32'h100, 0, 0); chk("mid_new_b1_iaddr", iaddr, 32'h104);
    step(1, 32'h100, 0, 0); chk("mid_new_hit", 32'(ihit), 32'h1);
    chk("mid_new_data", imemload, 32'hC0DE_0100);
    step(1, 32'h040, 0, 0); chk("mid_old_hit", 32'(ihit), 32'h1);
    chk("mid_old_data", imemload, 32'hAAAA_0001);

    // Flush in IDLE with a would-be hit, then both lines miss
    step(1, 32'h040, 1, 0); chk("flush_hit_suppressed", 32'(ihit), 32'h0);
    do_fetch(32'h040, 0, lat, data, wu); chk("flush_40_lat", 32'(lat), 32'd3);
    do_fetch(32'h100, 0, lat, data, wu); chk("flush_100_lat", 32'(lat), 32'd3);

    // Flush during a fill beat
    step(1, 32'h0C0, 0, 0); chk("ffill_miss_ihit", 32'(ihit), 32'h0);
    step(1, 32'h0C0, 1, 0); chk("ffill_iREN_before", 32'(iREN), 32'h1);
    step(0, 32'h0C0, 0, 0); chk("ffill_iREN_after", 32'(iREN), 32'h0);
    chk("ffill_ihit_after", 32'(ihit), 32'h0);
    do_fetch(32'h0C0, 0, lat, data, wu); chk("ffill_refetch_lat", 32'(lat), 32'd3);

    // Reset mid-fill: next cycle the previously valid 0xC0 does not hit
    step(1, 32'h200, 0, 0); chk("rfill_miss_ihit", 32'(ihit), 32'h0);
    step(1, 32'h200, 0, 1); chk("rfill_iREN_before", 32'(iREN), 32'h1);
    step(1, 32'h0C0, 0, 0); chk("rfill_iREN_after", 32'(iREN), 32'h0);
    chk("rfill_ihit_after", 32'(ihit), 32'h0);
    do_fetch(32'h0C0, 0, lat, data, wu); chk("rfill_c0_lat", 32'(lat), 32'd2);
    chk("rfill_c0_data", data, 32'hC0DE_00C0);

    // Randomized fetches and flushes against the reference model
    step(0, 32'h0, 0, 1);
    model_clear(1'b1);
    step(0, 32'h0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      bit exp_hit;
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 7)) << 3) |
          (32'($urandom_range(0, 1)) << 2);
      if ($urandom_range(0, 9) == 0) begin
        step(1'($urandom_range(0, 1)), a, 1, 0);
        chk("rnd_flush_ihit", 32'(ihit), 32'h0);
        model_clear(1'b0);
        $display("flush addr=%h", a);
      end else begin
        exp_hit = model_hit(a);
        do_fetch(a, -1, lat, data, wu);
        chk("rnd_lat", 32'(lat), exp_hit ? 32'd0 : 32'(1 + wu + BLKWORDS));
        chk("rnd_data", data, mem_data(a));
        if (!exp_hit) model_fill(a);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
